sprite_anim_seq: RTL and testbench

SPRITE_ANIM_SEQ -- requirements
Module: sprite_anim_seq

---
 rtl/anim_pkg.sv | 55 +++++
 rtl/anim_frame_rom.sv | 51 +++++
 rtl/sprite_anim_seq.sv | 132 +++++++++++++
 tb/tb_sprite_anim_seq.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/anim_pkg.sv
// rtl/anim_pkg.sv - shared types and frame-table constants for the sprite animation sequencer
package anim_pkg;

  localparam int ROW_BITS  = 7;
  localparam int COL_BITS  = 7;
  localparam int HOLD_BITS = 4;

  typedef enum logic [1:0] {
    ANIM_WALK  = 2'd0,
    ANIM_IDLE  = 2'd1,
    ANIM_SHELL = 2'd2,
    ANIM_HIT   = 2'd3
  } anim_id_t;

  typedef enum logic [1:0] {
    MODE_LOOP     = 2'd0,
    MODE_PINGPONG = 2'd1,
    MODE_ONESHOT  = 2'd2
  } anim_mode_t;

  typedef enum logic {
    ST_PLAY     = 1'b0,
    ST_FINISHED = 1'b1
  } seq_state_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  typedef struct packed {
    logic [ROW_BITS-1:0]  row;
    logic [COL_BITS-1:0]  col;
    logic [HOLD_BITS-1:0] hold;
  } frame_t;

  localparam int WALK_LEN  = 6;
  localparam int IDLE_LEN  = 1;
  localparam int SHELL_LEN = 4;
  localparam int HIT_LEN   = 3;

  localparam anim_mode_t WALK_MODE  = MODE_LOOP;
  localparam anim_mode_t IDLE_MODE  = MODE_LOOP;
  localparam anim_mode_t SHELL_MODE = MODE_PINGPONG;
  localparam anim_mode_t HIT_MODE   = MODE_ONESHOT;

  function automatic frame_t mk_frame(int row, int col, int hold);
    frame_t f;
    f.row  = ROW_BITS'(row);
    f.col  = COL_BITS'(col);
    f.hold = HOLD_BITS'(hold);
    return f;
  endfunction

endpackage

// File: rtl/anim_frame_rom.sv
// rtl/anim_frame_rom.sv - combinational frame table: (anim, frame) -> frame data, last index, mode
module anim_frame_rom
  import anim_pkg::*;
#(
  parameter int AW = 2,
  parameter int FW = 3
) (
  input  logic [AW-1:0] anim_i,
  input  logic [FW-1:0] frame_i,
  output frame_t        frame_o,
  output logic [FW-1:0] last_o,
  output logic          loop_o,
  output logic          pingpong_o
);

  anim_mode_t mode;
  int         f;

  always_comb begin
    f          = int'(frame_i);
    frame_o    = mk_frame(30, 0, 0);
    last_o     = FW'(WALK_LEN - 1);
    mode       = WALK_MODE;
    case (int'(anim_i))
      int'(ANIM_IDLE): begin
        frame_o = mk_frame(0, 0, 0);
        last_o  = FW'(IDLE_LEN - 1);
        mode    = IDLE_MODE;
      end
      int'(ANIM_SHELL): begin
        frame_o = mk_frame(90, 23 * f, 1);
        last_o  = FW'(SHELL_LEN - 1);
        mode    = SHELL_MODE;
      end
      int'(ANIM_HIT): begin
        frame_o = mk_frame(120, 23 * f, 2);
        last_o  = FW'(HIT_LEN - 1);
        mode    = HIT_MODE;
      end
      default: begin
        // WALK: two rows of three, middle column offset in each row
        frame_o = mk_frame((f < 3) ? 30 : 60, (f == 1 || f == 4) ? 23 : 0, 0);
        last_o  = FW'(WALK_LEN - 1);
        mode    = WALK_MODE;
      end
    endcase
    loop_o     = (mode == MODE_LOOP);
    pingpong_o = (mode == MODE_PINGPONG);
  end

endmodule

// File: rtl/sprite_anim_seq.sv
// rtl/sprite_anim_seq.sv - sprite animation sequencer; ANIM_PINGPONG_EN enables ping-pong playback
module sprite_anim_seq
  import anim_pkg::*;
#(
  parameter int NUM_ANIMS  = 4,
  parameter int MAX_FRAMES = 8,
  parameter int ROW_W      = 7,
  parameter int COL_W      = 7,
  parameter int HOLD_W     = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          anim_tick,
  input  logic [$clog2(NUM_ANIMS)-1:0]  anim_sel,
  input  logic                          restart,
  input  logic                          pause,
  output logic [ROW_W-1:0]              anim_row,
  output logic [COL_W-1:0]              anim_col,
  output logic [$clog2(MAX_FRAMES)-1:0] frame_idx,
  output logic                          busy,
  output logic                          done
);

  localparam int AW = $clog2(NUM_ANIMS);
  localparam int FW = $clog2(MAX_FRAMES);

  seq_state_t        state_q, state_d;
  logic [AW-1:0]     cur_anim_q, cur_anim_d;
  logic [FW-1:0]     frame_q, frame_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              done_q, done_d;
`ifdef ANIM_PINGPONG_EN
  dir_t              dir_q, dir_d;
`endif

  frame_t        fr;
  logic [FW-1:0] last;
  logic          is_loop, is_pp;
  logic [AW-1:0] sel_c;

  anim_frame_rom #(.AW(AW), .FW(FW)) u_rom (
    .anim_i     (cur_anim_q),
    .frame_i    (frame_q),
    .frame_o    (fr),
    .last_o     (last),
    .loop_o     (is_loop),
    .pingpong_o (is_pp)
  );

  assign sel_c = ({1'b0, anim_sel} >= (AW+1)'(NUM_ANIMS)) ? '0 : anim_sel;

  always_comb begin
    state_d    = state_q;
    cur_anim_d = cur_anim_q;
    frame_d    = frame_q;
    hold_d     = hold_q;
    done_d     = 1'b0;
`ifdef ANIM_PINGPONG_EN
    dir_d      = dir_q;
`endif
    if (sel_c != cur_anim_q || restart) begin
      cur_anim_d = sel_c;
      frame_d    = '0;
      hold_d     = '0;
      state_d    = ST_PLAY;
`ifdef ANIM_PINGPONG_EN
      dir_d      = DIR_UP;
`endif
    end else if (!pause && anim_tick && state_q == ST_PLAY) begin
      if (hold_q < HOLD_W'(fr.hold)) begin
        hold_d = hold_q + 1'b1;
      end else begin
        hold_d = '0;
`ifdef ANIM_PINGPONG_EN
        if (is_pp && last != '0) begin
          // bounce at both ends so the end frames are shown once per pass
          if (dir_q == DIR_UP) begin
            if (frame_q == last) begin
              dir_d   = DIR_DOWN;
              frame_d = frame_q - 1'b1;
            end else begin
              frame_d = frame_q + 1'b1;
            end
          end else if (frame_q == '0) begin
            dir_d   = DIR_UP;
            frame_d = frame_q + 1'b1;
          end else begin
            frame_d = frame_q - 1'b1;
          end
        end else
`endif
        if (frame_q < last) begin
          frame_d = frame_q + 1'b1;
        end else if (is_loop || is_pp) begin
          frame_d = '0;
        end else begin
          state_d = ST_FINISHED;
          done_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_PLAY;
      cur_anim_q <= '0;
      frame_q    <= '0;
      hold_q     <= '0;
      done_q     <= 1'b0;
`ifdef ANIM_PINGPONG_EN
      dir_q      <= DIR_UP;
`endif
    end else begin
      state_q    <= state_d;
      cur_anim_q <= cur_anim_d;
      frame_q    <= frame_d;
      hold_q     <= hold_d;
      done_q     <= done_d;
`ifdef ANIM_PINGPONG_EN
      dir_q      <= dir_d;
`endif
    end
  end

  assign anim_row  = ROW_W'(fr.row);
  assign anim_col  = COL_W'(fr.col);
  assign frame_idx = frame_q;
  assign busy      = (state_q == ST_PLAY);
  assign done      = done_q;

endmodule

// File: tb/tb_sprite_anim_seq.sv
// tb/tb_sprite_anim_seq.sv - self-checking bench for sprite_anim_seq (tick-count reference model)
module tb_sprite_anim_seq;

  localparam int NUM_ANIMS = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0, anim_tick = 1'b0, restart = 1'b0, pause = 1'b0;
  logic [1:0] anim_sel = 2'd0;
  logic [6:0] anim_row, anim_col;
  logic [2:0] frame_idx;
  logic       busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sprite_anim_seq dut (
    .clk       (clk),
    .reset     (reset),
    .anim_tick (anim_tick),
    .anim_sel  (anim_sel),
    .restart   (restart),
    .pause     (pause),
    .anim_row  (anim_row),
    .anim_col  (anim_col),
    .frame_idx (frame_idx),
    .busy      (busy),
    .done      (done)
  );

  // Reference data: mode 0 loop, 1 ping-pong, 2 one-shot
  int t_len[4]  = '{6, 1, 4, 3};
  int t_hold[4] = '{0, 0, 1, 2};
  int t_mode[4] = '{0, 0, 1, 2};
  int tab_row[4][6] = '{'{30, 30, 30, 60, 60, 60}, '{0, 0, 0, 0, 0, 0},
                        '{90, 90, 90, 90, 0, 0}, '{120, 120, 120, 0, 0, 0}};
  int tab_col[4][6] = '{'{0, 23, 0, 0, 23, 0}, '{0, 0, 0, 0, 0, 0},
                        '{0, 23, 46, 69, 0, 0}, '{0, 23, 46, 0, 0, 0}};

  // The model tracks only the number of accepted ticks since the animation started.
  function automatic bit m_finished(int a, int t);
    return t_mode[a] == 2 && t >= t_len[a] * (t_hold[a] + 1);
  endfunction

  function automatic int m_frame(int a, int t);
    int step, len, cyc, s;
    step = t / (t_hold[a] + 1);
    len  = t_len[a];
    if (t_mode[a] == 2) return (step >= len) ? len - 1 : step;
`ifdef ANIM_PINGPONG_EN
    if (t_mode[a] == 1 && len > 1) begin
      cyc = 2 * (len - 1);
      s   = step % cyc;
      return (s < len) ? s : cyc - s;
    end
`endif
    cyc = 0;
    s   = 0;
    return step % len;
  endfunction

  task automatic chk(string nm, int act, int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  int m_anim = 0, m_t = 0, m_sel = 0;
  bit m_done = 1'b0, m_valid = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_anim  = 0;
      m_t     = 0;
      m_done  = 1'b0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      m_done = 1'b0;
      m_sel  = (int'(anim_sel) >= NUM_ANIMS) ? 0 : int'(anim_sel);
      if (m_sel != m_anim || restart) begin
        m_anim = m_sel;
        m_t    = 0;
      end else if (!pause && anim_tick && !m_finished(m_anim, m_t)) begin
        m_t++;
        if (m_finished(m_anim, m_t)) m_done = 1'b1;
      end
    end
  end

  int cf;
  always @(negedge clk) begin
    if (m_valid) begin
      cf = m_frame(m_anim, m_t);
      chk("row",   int'(anim_row),  tab_row[m_anim][cf]);
      chk("col",   int'(anim_col),  tab_col[m_anim][cf]);
      chk("frame", int'(frame_idx), cf);
      chk("busy",  int'(busy),      int'(!m_finished(m_anim, m_t)));
      chk("done",  int'(done),      int'(m_done));
    end
  end

  task automatic cyc(bit tk, int sel, bit rs = 1'b0, bit ps = 1'b0, bit rst = 1'b0);
    logic [1:0] s2;
    s2        = sel[1:0];
    anim_tick = tk;
    anim_sel  = s2;
    restart   = rs;
    pause     = ps;
    reset     = rst;
    @(posedge clk);
    #2;
  endtask

  int walk_row[6] = '{30, 30, 30, 60, 60, 60};
  int walk_col[6] = '{0, 23, 0, 0, 23, 0};
`ifdef ANIM_PINGPONG_EN
  int shell_seq[14] = '{0, 0, 1, 1, 2, 2, 3, 3, 2, 2, 1, 1, 0, 0};
`else
  int shell_seq[14] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0, 1, 1, 2, 2};
`endif

  initial begin
    int dcount, cur_sel;
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0);
    chk("rst_row", int'(anim_row), 30);
    chk("rst_col", int'(anim_col), 0);
    chk("rst_busy", int'(busy), 1);
    chk("rst_done", int'(done), 0);
    chk("rst_frame", int'(frame_idx), 0);

    for (int k = 1; k <= 7; k++) begin
      cyc(1, 0);
      chk("walk_row", int'(anim_row), walk_row[k % 6]);
      chk("walk_col", int'(anim_col), walk_col[k % 6]);
    end

    cyc(0, 3);
    chk("hit_start", int'(anim_row), 120);
    dcount = 0;
    for (int k = 1; k <= 9; k++) begin
      cyc(1, 3);
      dcount += int'(done);
      chk("hit_frame", int'(frame_idx), (k < 9) ? k / 3 : 2);
    end
    chk("hit_done", int'(done), 1);
    chk("hit_busy", int'(busy), 0);
    for (int k = 0; k < 3; k++) begin
      cyc(1, 3);
      dcount += int'(done);
      chk("hit_hold_col", int'(anim_col), 46);
      chk("hit_hold_row", int'(anim_row), 120);
      chk("hit_hold_busy", int'(busy), 0);
    end
    chk("hit_done_cnt", dcount, 1);

    cyc(0, 0);
    for (int k = 0; k < 4; k++) cyc(1, 0);
    chk("walk_f4", int'(frame_idx), 4);
    cyc(0, 2);
    chk("sel_frame", int'(frame_idx), 0);
    chk("sel_row", int'(anim_row), 90);
    chk("sel_col", int'(anim_col), 0);
    chk("sel_done", int'(done), 0);

    cyc(1, 2);
    chk("pause_pre", int'(frame_idx), 0);
    for (int k = 0; k < 5; k++) begin
      cyc(1, 2, 0, 1);
      chk("pause_frame", int'(frame_idx), 0);
    end
    cyc(1, 2);
    chk("pause_rel", int'(frame_idx), 1);
    chk("pause_col", int'(anim_col), 23);

    cyc(0, 2, 1);
    for (int k = 0; k < 14; k++) begin
      chk("shell_seq", int'(frame_idx), shell_seq[k]);
      cyc(1, 2);
    end

    cyc(0, 3);
    for (int k = 0; k < 10; k++) cyc(1, 3);
    chk("fin_busy", int'(busy), 0);
    cyc(1, 3, 0, 0, 1);
    chk("rst_fin_row", int'(anim_row), 30);
    chk("rst_fin_col", int'(anim_col), 0);
    chk("rst_fin_busy", int'(busy), 1);
    chk("rst_fin_done", int'(done), 0);

    cur_sel = 0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom % 20 == 0) cur_sel = int'($urandom_range(0, 3));
      cyc(($urandom % 10) < 6, cur_sel, ($urandom % 33) == 0,
          ($urandom % 7) == 0, ($urandom % 150) == 0);
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
